// File: rtl/fwb_pkg.sv
// Shared constants for the FP register-file write-back arbiter.
//   FWB_NREQ       default number of write-back requesters
//   FWB_IDW        width of a requester index
//   FWB_ADD..MEM   requester slots for the FP units
//   FREG_CONST_*   inclusive range of constant-ROM registers
//   freg_writable  1 when a write to addr may reach the register file
package fwb_pkg;

  localparam int unsigned FWB_NREQ = 4;
  localparam int unsigned FWB_IDW  = 3;

  localparam int unsigned FWB_ADD = 0;
  localparam int unsigned FWB_MUL = 1;
  localparam int unsigned FWB_DIV = 2;
  localparam int unsigned FWB_MEM = 3;

  localparam int unsigned FREG_CONST_LO = 11;
  localparam int unsigned FREG_CONST_HI = 29;

  // f0 and the constant ROM window are read-only.
  function automatic logic freg_writable(input logic [31:0] addr);
    return (addr != 32'd0) &&
           !((addr >= 32'(FREG_CONST_LO)) && (addr <= 32'(FREG_CONST_HI)));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst   clock, asynchronous active-high reset
//   req        request vector
//   en         arbitration enable; 0 forces no grant
//   gnt_c      combinational one-hot grant (or zero)
//   gnt_idx_c  combinational index of the granted requester
module rr_arbiter
  import fwb_pkg::*;
#(
  parameter int unsigned NREQ = FWB_NREQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic                 en,
  output logic [NREQ-1:0]      gnt_c,
  output logic [FWB_IDW-1:0]   gnt_idx_c
);

  localparam int unsigned IW = FWB_IDW;

  logic [IW-1:0] ptr;
  logic          found;

  // Search indices >= ptr first, then wrap to indices below ptr.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found     = 1'b0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (en && !found && req[j] && (IW'(j) >= ptr)) begin
        found     = 1'b1;
        gnt_c[j]  = 1'b1;
        gnt_idx_c = IW'(j);
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      if (en && !found && req[j] && (IW'(j) < ptr)) begin
        found     = 1'b1;
        gnt_c[j]  = 1'b1;
        gnt_idx_c = IW'(j);
      end
    end
  end

  // Pointer moves past the winner; wraps explicitly for non-power-of-two NREQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx_c == IW'(NREQ - 1)) ? '0 : gnt_idx_c + IW'(1);
    end
  end

endmodule

// File: rtl/fwb_arbiter.sv
// Write-back arbiter for the single FP register-file write port.
//   clk, rst    clock, asynchronous active-high reset
//   freeze      pipeline hold, blocks new grants
//   req_valid   per-requester write request
//   req_ready   per-requester grant (combinational, one-hot or zero)
//   req_addr    packed destination registers, AW bits per requester
//   req_data    packed write data, DW bits per requester
//   fwe         registered register-file write enable
//   rd_addr     registered write address
//   wdata       registered write data
//   drop        registered pulse: last accepted write hit a protected register
//   gnt_id      registered index of the requester behind fwe/drop
module fwb_arbiter
  import fwb_pkg::*;
#(
  parameter int unsigned NREQ = FWB_NREQ,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 fwe,
  output logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        wdata,
  output logic                 drop,
  output logic [2:0]           gnt_id
);

  logic [NREQ-1:0]    gnt_c;
  logic [FWB_IDW-1:0] gnt_idx_c;
  logic               any_gnt_c;
  logic               wr_ok_c;
  logic [AW-1:0]      sel_addr_c;
  logic [DW-1:0]      sel_data_c;

  // No grant while held in reset, so nothing is acknowledged and then lost.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (!freeze && !rst),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c)
  );

  assign req_ready = gnt_c;
  assign any_gnt_c = |gnt_c;

  // AND-OR mux on the one-hot grant.
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      sel_addr_c = sel_addr_c | (req_addr[j*AW +: AW] & {AW{gnt_c[j]}});
      sel_data_c = sel_data_c | (req_data[j*DW +: DW] & {DW{gnt_c[j]}});
    end
  end

  assign wr_ok_c = freg_writable(32'(sel_addr_c));

  // Output stage; a filtered write leaves address/data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwe     <= 1'b0;
      drop    <= 1'b0;
      rd_addr <= '0;
      wdata   <= '0;
      gnt_id  <= '0;
    end else begin
      fwe  <= any_gnt_c && wr_ok_c;
      drop <= any_gnt_c && !wr_ok_c;
      if (any_gnt_c) begin
        gnt_id <= 3'(gnt_idx_c);
      end
      if (any_gnt_c && wr_ok_c) begin
        rd_addr <= sel_addr_c;
        wdata   <= sel_data_c;
      end
    end
  end

endmodule
